// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg : shared divider state codes and handshake constants
// rev 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // Encodings are shared with the execute stage.
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// div_unit_if : execute-stage <-> divider request/result bundle
// rev 1.0
// ============================================================================
`default_nettype none

interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// div_step : one combinational restoring-division iteration
// rev 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   sr_in,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] sr_out,
    output logic               q_bit
);
    logic             fits;
    logic [WIDTH-1:0] diff;

    // The trial window is WIDTH+1 bits wide, so a partial remainder of up to
    // 2*divisor-1 is compared exactly; the surviving difference is < divisor
    // and therefore fits back into WIDTH bits.
    always_comb begin
        fits   = (sr_in[2*WIDTH:WIDTH] >= {1'b0, divisor});
        diff   = sr_in[2*WIDTH-1:WIDTH] - divisor;
        q_bit  = fits;
        sr_out = fits ? {diff, sr_in[WIDTH-1:0]} : sr_in[2*WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : multi-cycle radix-2 restoring divider for DIV/DIVU
// Optional feature macro: DIV_EARLY_OUT_EN | rev 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e           state, state_nxt;
    logic [2*WIDTH:0]     sr, sr_nxt;
    logic [WIDTH-1:0]     divisor, divisor_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 neg_quot, neg_quot_nxt;
    logic                 neg_rem, neg_rem_nxt;
    logic [2*WIDTH-1:0]   res, res_nxt;
    logic [2*WIDTH-1:0]   result, result_nxt;
    logic                 ready, ready_nxt;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;
    logic [2*WIDTH-1:0]   step_hi;
    logic                 step_q;
    logic                 go;

    assign go   = (bus.start_i == DIV_START) && !bus.annul_i;
    assign mag1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .sr_in   (sr),
        .divisor (divisor),
        .sr_out  (step_hi),
        .q_bit   (step_q)
    );

    // After WIDTH steps the quotient sits in the low half and the remainder
    // in the top WIDTH bits of the shift register.
    assign quot     = sr[WIDTH-1:0];
    assign rem      = sr[2*WIDTH:WIDTH+1];
    assign quot_fix = neg_quot ? -quot : quot;
    assign rem_fix  = neg_rem  ? -rem  : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            sr       <= '0;
            divisor  <= '0;
            cnt      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            res      <= '0;
            result   <= '0;
            ready    <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            divisor  <= divisor_nxt;
            cnt      <= cnt_nxt;
            neg_quot <= neg_quot_nxt;
            neg_rem  <= neg_rem_nxt;
            res      <= res_nxt;
            result   <= result_nxt;
            ready    <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        divisor_nxt  = divisor;
        cnt_nxt      = cnt;
        neg_quot_nxt = neg_quot;
        neg_rem_nxt  = neg_rem;
        res_nxt      = res;
        result_nxt   = '0;
        ready_nxt    = DIV_RESULT_NOT_READY;

        case (state)
            DIV_FREE: begin
                if (go) begin
                    if (bus.opdata2_i == '0) begin
                        state_nxt = DIV_BYZERO;
                        res_nxt   = '0;
                    end
`ifdef DIV_EARLY_OUT_EN
                    // Early-out shares the one-cycle BYZERO hop so both short
                    // paths deliver ready_o with the same 2-edge latency.
                    else if (mag1 < mag2) begin
                        state_nxt = DIV_BYZERO;
                        res_nxt   = {bus.opdata1_i, {WIDTH{1'b0}}};
                    end
`endif
                    else begin
                        state_nxt    = DIV_ON;
                        sr_nxt       = {{WIDTH{1'b0}}, mag1, 1'b0};
                        divisor_nxt  = mag2;
                        cnt_nxt      = '0;
                        neg_quot_nxt = bus.signed_div_i &&
                                       (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_rem_nxt  = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
                    end
                end
            end

            DIV_BYZERO: begin
                state_nxt = bus.annul_i ? DIV_FREE : DIV_END;
            end

            DIV_ON: begin
                if (bus.annul_i) begin
                    state_nxt = DIV_FREE;
                end else if (cnt != CNT_LAST) begin
                    sr_nxt  = {step_hi, step_q};
                    cnt_nxt = cnt + CNT_ONE;
                end else begin
                    res_nxt   = {rem_fix, quot_fix};
                    cnt_nxt   = '0;
                    state_nxt = DIV_END;
                end
            end

            DIV_END: begin
                if (go) begin
                    ready_nxt  = DIV_RESULT_READY;
                    result_nxt = res;
                end else begin
                    state_nxt = DIV_FREE;
                end
            end

            default: begin
                state_nxt = DIV_FREE;
            end
        endcase
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : randomized self-checking bench for div_unit
// rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
    import div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 32'd0) return 2;
        if (EARLY && (ma < mb)) return 2;
        return 34;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level expectation of the outputs after every edge.
    logic        exp_ready  = 1'b0;
    logic [63:0] exp_result = 64'd0;
    bit          m_active   = 1'b0;
    int          m_age      = 0;
    int          m_lat      = 0;
    logic [63:0] m_val      = 64'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active   <= 1'b0;
            exp_ready  <= 1'b0;
            exp_result <= 64'd0;
        end else if (!m_active) begin
            exp_ready  <= 1'b0;
            exp_result <= 64'd0;
            if (bus.start_i && !bus.annul_i) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_lat    <= lat_of(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
                m_val    <= ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 < m_lat) begin
                if (bus.annul_i) m_active <= 1'b0;
            end else if (bus.start_i && !bus.annul_i) begin
                exp_ready  <= 1'b1;
                exp_result <= m_val;
            end else begin
                m_active   <= 1'b0;
                exp_ready  <= 1'b0;
                exp_result <= 64'd0;
            end
        end
    end

    always @(negedge clk) begin
        check("cycle_ready",  {63'd0, bus.ready_o}, {63'd0, exp_ready});
        check("cycle_result", bus.result_o, exp_result);
    end

    // ---------------- stimulus ----------------
    task automatic scramble();
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int annul_at, input int rst_at, input int lit_lat,
                          input bit chk_lit, input logic [63:0] lit);
        int first, want, limit, extra;
        bit aborted, seen;
        first   = -1;
        aborted = 1'b0;
        want    = (lit_lat >= 0) ? lit_lat : lat_of(a, b, s);
        limit   = want + 4;

        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;

        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                first = k - 1;
                break;
            end
            if (k - 1 == annul_at) begin
                aborted = 1'b1;
                break;
            end
            if (k - 1 == rst_at) begin
                #2;
                rst         = 1'b0;
                bus.start_i = 1'b0;
                #1;
                check("async_rst_ready",  {63'd0, bus.ready_o}, 64'd0);
                check("async_rst_result", bus.result_o, 64'd0);
                @(negedge clk);
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
            bus.annul_i = (k == annul_at);
            scramble();
        end

        if (aborted) begin
            bus.annul_i = 1'b0;
            bus.start_i = 1'b0;
            seen        = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (bus.ready_o) seen = 1'b1;
            end
            check("no_ready_after_abort", {63'd0, seen}, 64'd0);
        end else begin
            check("latency", 64'(first), 64'(want));
            if (chk_lit) check("result_literal", bus.result_o, lit);
            extra = $urandom_range(0, 2);
            repeat (extra) @(negedge clk);
            bus.start_i = 1'b0;
            @(negedge clk);
            check("ready_drop", {63'd0, bus.ready_o}, 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;

        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;

        // Pin the reference model itself.
        check("model_divu_100_7",  ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("model_div_m7_2",    ref_div(-32'sd7, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("model_div_7_m2",    ref_div(32'd7, -32'sd2, 1'b1), {32'd1, 32'hFFFFFFFD});
        check("model_overflow",    ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});

        repeat (3) @(negedge clk);
        check("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0, -1, -1, 34, 1'b1, {32'd2, 32'd14});
        do_div(-32'sd7, 32'd2, 1'b1, -1, -1, 34, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_div(32'd7, -32'sd2, 1'b1, -1, -1, 34, 1'b1, {32'd1, 32'hFFFFFFFD});
        do_div(32'd12345, 32'd0, 1'b0, -1, -1, 2, 1'b1, 64'd0);
        do_div(-32'sd5, 32'd0, 1'b1, -1, -1, 2, 1'b1, 64'd0);
        do_div(32'd1000, 32'd3, 1'b0, 10, -1, -1, 1'b0, 64'd0);
        do_div(32'd1000, 32'd3, 1'b0, -1, -1, 34, 1'b1, {32'd1, 32'd333});
        do_div(32'hFFFFFFFF, 32'd5, 1'b0, -1, 20, -1, 1'b0, 64'd0);
        do_div(32'd50, 32'd5, 1'b0, -1, -1, 34, 1'b1, {32'd0, 32'd10});
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, -1, 34, 1'b1, {32'd0, 32'h80000000});
        do_div(32'd3, 32'd10, 1'b0, -1, -1, EARLY ? 2 : 34, 1'b1, {32'd3, 32'd0});

        // Asynchronous reset while a result is being presented.
        @(negedge clk);
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b1;
        repeat (3) @(negedge clk);
        check("end_ready_before_rst", {63'd0, bus.ready_o}, 64'd1);
        #2;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("end_rst_ready", {63'd0, bus.ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, -1, -1, -1, 1'b0, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
